// File: rtl/bcd_disp_pkg.sv
// Shared constants, state type and helpers for the multiplexed BCD display scanner.
package bcd_disp_pkg;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         MAX_DIGITS = 16;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    // One-hot enable for digit d; bits at or above num_digits stay clear.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [3:0] d, input int num_digits);
        logic [MAX_DIGITS-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < num_digits) && (d == 4'(i))) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Bit i set when digit i and every digit above it are zero. Digit 0 is never
    // suppressed. Unused upper digits must be zero-filled by the caller, which
    // makes them transparent to the leading-zero chain.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] disp);
        logic [MAX_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS-1; i >= 1; i--) begin
            all_zero = all_zero && (disp[4*i +: 4] == 4'h0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_slot_timer.sv
// Slot timer: slot counter k, digit index d, BLANK/SCAN phase and frame_done.
// Next-state values are exported so the top can register its outputs aligned
// with the same k the timer is in.
module bcd_slot_timer
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_nxt_o,
    output logic                          scan_nxt_o,
    output logic                          frame_done_o
);

    localparam int KW = $clog2(PRESCALE);
    localparam int DW = $clog2(NUM_DIGITS);

    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] d_q, d_d;
    logic          frame_done_q, frame_done_d;
    logic          k_last;
    scan_state_t   state_q, state_d;

    // Slot counter and digit index advance; frame_done is precomputed one cycle ahead.
    always_comb begin
        k_last = (k_q == KW'(PRESCALE-1));
        k_d    = k_last ? '0 : k_q + KW'(1);
        d_d    = d_q;
        if (k_last) begin
            d_d = (d_q == DW'(NUM_DIGITS-1)) ? '0 : d_q + DW'(1);
        end
        frame_done_d = (k_d == KW'(PRESCALE-1)) && (d_d == DW'(NUM_DIGITS-1));
    end

    // Phase FSM next state: blank for the first BLANK_CYCLES of each slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (k_q == KW'(BLANK_CYCLES-1)) state_d = SCAN;
            SCAN:    if (k_last)                     state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // Timer and phase registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q          <= '0;
            d_q          <= '0;
            state_q      <= BLANK;
            frame_done_q <= 1'b0;
        end else begin
            k_q          <= k_d;
            d_q          <= d_d;
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_nxt_o  = d_d;
    assign scan_nxt_o   = (state_d == SCAN);
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed N-digit 7-segment scanner. New values enter through a
// valid/ready handshake into a pending register and reach the display
// register only at frame boundaries, so a frame never mixes old and new digits.
module bcd_digit_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int DW = $clog2(NUM_DIGITS);
    localparam int W  = 4*NUM_DIGITS;

    logic [DW-1:0]           digit_nxt;
    logic                    scan_nxt;
    logic                    boundary;
    logic                    xfer;

    logic [W-1:0]            disp_q, disp_d;
    logic [W-1:0]            pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [3:0]              bcd_q, bcd_d;

    logic [4*MAX_DIGITS-1:0] disp_ext;
    logic [MAX_DIGITS-1:0]   oh_full;
    logic [MAX_DIGITS-1:0]   lz_full;
    logic [3:0]              nib;
    logic                    sup;

    bcd_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i        (clk),
        .rst_i        (rst),
        .digit_nxt_o  (digit_nxt),
        .scan_nxt_o   (scan_nxt),
        .frame_done_o (boundary)
    );

    // Handshake and frame-boundary update of the pending/display registers.
    always_comb begin
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        xfer         = load_valid && !pend_valid_q;
        if (boundary && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end else if (boundary && xfer) begin
            disp_d = load_data;
        end else if (xfer) begin
            pend_d       = load_data;
            pend_valid_d = 1'b1;
        end
    end

    // Output selection for the coming cycle, using the display value that will be live then.
    always_comb begin
        disp_ext        = '0;
        disp_ext[W-1:0] = disp_d;
        oh_full         = onehot(4'(digit_nxt), NUM_DIGITS);
        lz_full         = lz_mask(disp_ext);
        nib             = BCD_BLANK;
        sup             = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_nxt == DW'(i)) begin
                nib = disp_d[4*i +: 4];
                sup = lz_full[i];
            end
        end
        digit_en_d = '0;
        bcd_d      = BCD_BLANK;
        if (scan_nxt) begin
            digit_en_d = oh_full[NUM_DIGITS-1:0];
            bcd_d      = ((LZ_SUPPRESS != 0) && sup) ? BCD_BLANK : nib;
        end
    end

    generate
        if (NUM_DIGITS < MAX_DIGITS) begin : g_spare
            logic unused_spare;
            assign unused_spare = ^{oh_full[MAX_DIGITS-1:NUM_DIGITS], lz_full[MAX_DIGITS-1:NUM_DIGITS]};
        end
    endgenerate

    // Data and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            digit_en_q   <= '0;
            bcd_q        <= BCD_BLANK;
        end else begin
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            digit_en_q   <= digit_en_d;
            bcd_q        <= bcd_d;
        end
    end

    assign load_ready = !pend_valid_q;
    assign bcd_out    = bcd_q;
    assign digit_en   = digit_en_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner with a cycle model feeding a scoreboard.
module tb_bcd_digit_scanner;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0;
    logic        load_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    bcd_digit_scanner #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLANK_CYCLES (B),
        .LZ_SUPPRESS  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .bcd_out    (bcd_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] bcd;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          mk, md;
    logic [15:0] mdisp, mpend;
    logic        mpv;

    function automatic logic lz_sup(input logic [15:0] disp, input int i);
        if (i == 0) return 1'b0;
        for (int j = i; j < N; j++) begin
            if (disp[j*4 +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.rdy = !mpv;
        e.fd  = (mk == P-1) && (md == N-1);
        if (mk < B) begin
            e.en  = 4'h0;
            e.bcd = 4'hF;
        end else begin
            e.en  = 4'(1 << md);
            e.bcd = lz_sup(mdisp, md) ? 4'hF : mdisp[md*4 +: 4];
        end
        return e;
    endfunction

    task automatic model_tick(input logic r, input logic v, input logic [15:0] dat);
        logic xfer, bnd;
        if (r) begin
            mk = 0; md = 0; mdisp = 16'h0; mpend = 16'h0; mpv = 1'b0;
        end else begin
            xfer = v && !mpv;
            bnd  = (mk == P-1) && (md == N-1);
            if (bnd && mpv) begin
                mdisp = mpend; mpv = 1'b0;
            end else if (bnd && xfer) begin
                mdisp = dat;
            end else if (xfer) begin
                mpend = dat; mpv = 1'b1;
            end
            if (mk == P-1) begin
                mk = 0;
                md = (md == N-1) ? 0 : md + 1;
            end else begin
                mk = mk + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] dat);
        exp_t e;
        rst        = r;
        load_valid = v;
        load_data  = dat;
        model_tick(r, v, dat);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("sb_digit_en",   digit_en,            e.en);
        chk("sb_bcd_out",    bcd_out,             e.bcd);
        chk("sb_frame_done", {3'b0, frame_done},  {3'b0, e.fd});
        chk("sb_load_ready", {3'b0, load_ready},  {3'b0, e.rdy});
    endtask

    task automatic run_to(input int d, input int k, input logic v, input logic [15:0] dat);
        int n;
        n = 0;
        while (!(md == d && mk == k) && n < 100) begin
            step(1'b0, v, dat);
            n++;
        end
        if (!(md == d && mk == k)) begin
            n_assert++;
            n_fail++;
            $error("FAIL run_to_bound cycle=%0d observed=d%0d/k%0d expected=d%0d/k%0d", cyc, md, mk, d, k);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] en, input logic [3:0] bcd);
        chk({tag, "_en"},  digit_en, en);
        chk({tag, "_bcd"}, bcd_out,  bcd);
    endtask

    initial begin
        mk = 0; md = 0; mdisp = 16'h0; mpend = 16'h0; mpv = 1'b0;
        @(posedge clk);
        #1;

        // 1. reset and the empty display
        repeat (3) step(1'b1, 1'b0, 16'h0);
        chk_out("reset", 4'b0000, 4'hF);
        chk("reset_ready", {3'b0, load_ready}, 4'h1);
        chk("reset_fd",    {3'b0, frame_done}, 4'h0);
        run_to(0, 1, 1'b0, 16'h0);
        chk_out("f0_blank", 4'b0000, 4'hF);
        run_to(0, 2, 1'b0, 16'h0);
        chk_out("f0_d0", 4'b0001, 4'h0);
        run_to(1, 2, 1'b0, 16'h0);
        chk_out("f0_d1", 4'b0010, 4'hF);
        run_to(3, 7, 1'b0, 16'h0);
        chk("f0_fd_c31", {3'b0, frame_done}, 4'h1);
        chk("f0_fd_cyc", 4'(cyc - 3), 4'(31));

        // 2. load 1234 mid-frame
        run_to(1, 4, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h1234);
        chk("load1234_ready", {3'b0, load_ready}, 4'h0);
        run_to(0, 0, 1'b0, 16'h0);
        chk_out("f2_blank", 4'b0000, 4'hF);
        run_to(0, 3, 1'b0, 16'h0);
        chk_out("f2_d0", 4'b0001, 4'h4);
        run_to(1, 3, 1'b0, 16'h0);
        chk_out("f2_d1", 4'b0010, 4'h3);
        run_to(2, 3, 1'b0, 16'h0);
        chk_out("f2_d2", 4'b0100, 4'h2);
        run_to(3, 3, 1'b0, 16'h0);
        chk_out("f2_d3", 4'b1000, 4'h1);

        // 3. leading zeros on 0050
        step(1'b0, 1'b1, 16'h0050);
        run_to(0, 4, 1'b0, 16'h0);
        chk_out("f3_d0", 4'b0001, 4'h0);
        run_to(1, 4, 1'b0, 16'h0);
        chk_out("f3_d1", 4'b0010, 4'h5);
        run_to(2, 4, 1'b0, 16'h0);
        chk_out("f3_d2", 4'b0100, 4'hF);
        run_to(3, 4, 1'b0, 16'h0);
        chk_out("f3_d3", 4'b1000, 4'hF);

        // 4. back-pressure: 1111 then 2222 with valid held
        run_to(0, 1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h1111);
        chk("bp_ready_low", {3'b0, load_ready}, 4'h0);
        run_to(3, 7, 1'b1, 16'h2222);
        chk("bp_ready_bnd", {3'b0, load_ready}, 4'h0);
        chk("bp_fd_bnd",    {3'b0, frame_done}, 4'h1);
        step(1'b0, 1'b1, 16'h2222);
        chk("bp_ready_free", {3'b0, load_ready}, 4'h1);
        step(1'b0, 1'b1, 16'h2222);
        chk("bp_ready_2222", {3'b0, load_ready}, 4'h0);
        run_to(0, 2, 1'b0, 16'h0);
        chk_out("f5_d0", 4'b0001, 4'h1);
        run_to(3, 2, 1'b0, 16'h0);
        chk_out("f5_d3", 4'b1000, 4'h1);
        run_to(0, 2, 1'b0, 16'h0);
        chk_out("f6_d0", 4'b0001, 4'h2);
        run_to(3, 2, 1'b0, 16'h0);
        chk_out("f6_d3", 4'b1000, 4'h2);

        // 5. invalid nibble counts as nonzero
        step(1'b0, 1'b1, 16'h00A7);
        run_to(0, 2, 1'b0, 16'h0);
        chk_out("f7_d0", 4'b0001, 4'h7);
        run_to(1, 2, 1'b0, 16'h0);
        chk_out("f7_d1", 4'b0010, 4'hA);
        run_to(2, 2, 1'b0, 16'h0);
        chk_out("f7_d2", 4'b0100, 4'hF);
        run_to(3, 2, 1'b0, 16'h0);
        chk_out("f7_d3", 4'b1000, 4'hF);

        // 6. reset mid-frame with pending full
        step(1'b0, 1'b1, 16'h9876);
        run_to(0, 3, 1'b0, 16'h0);
        chk_out("f8_d0", 4'b0001, 4'h6);
        step(1'b0, 1'b1, 16'h4321);
        run_to(2, 5, 1'b0, 16'h0);
        chk_out("f8_d2", 4'b0100, 4'h8);
        chk("pre_rst_ready", {3'b0, load_ready}, 4'h0);
        step(1'b1, 1'b0, 16'h0);
        chk_out("midrst", 4'b0000, 4'hF);
        chk("midrst_ready", {3'b0, load_ready}, 4'h1);
        chk("midrst_fd",    {3'b0, frame_done}, 4'h0);
        run_to(0, 2, 1'b0, 16'h0);
        chk_out("post_d0", 4'b0001, 4'h0);
        run_to(1, 2, 1'b0, 16'h0);
        chk_out("post_d1", 4'b0010, 4'hF);
        run_to(2, 2, 1'b0, 16'h0);
        chk_out("post_d2", 4'b0100, 4'hF);
        run_to(3, 2, 1'b0, 16'h0);
        chk_out("post_d3", 4'b1000, 4'hF);
        run_to(3, 7, 1'b0, 16'h0);
        chk("post_fd", {3'b0, frame_done}, 4'h1);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
